// File: rtl/bp_pkg.sv
// Shared definitions for the branch target buffer and branch_prediction:
// 2-bit predictor counter encodings and next-PC mux select encodings.
package bp_pkg;

    // 2-bit saturating predictor states; bit 1 is the taken prediction.
    localparam logic [1:0] CTR_SNT = 2'b00;  // strongly not-taken
    localparam logic [1:0] CTR_WNT = 2'b01;  // weakly not-taken
    localparam logic [1:0] CTR_WT  = 2'b10;  // weakly taken
    localparam logic [1:0] CTR_ST  = 2'b11;  // strongly taken

    // Next-PC mux select encodings consumed by branch_prediction.
    localparam logic [1:0] MUX_PC_PLUS4     = 2'd0;
    localparam logic [1:0] MUX_TARGET_S1    = 2'd1;
    localparam logic [1:0] MUX_FALLTHROUGH4 = 2'd2;
    localparam logic [1:0] MUX_TARGET_S4    = 2'd3;

endpackage

// File: rtl/branch_target_buffer_sat_ctr2.sv
// 2-bit saturating up/down counter step: purely combinational next-state.
module sat_ctr2
    import bp_pkg::*;
(
    input  logic [1:0] cur,
    input  logic       inc,
    output logic [1:0] nxt
);

    // Step one toward ST when inc, toward SNT otherwise; hold at the rails.
    always_comb begin
        nxt = cur;
        if (inc) begin
            if (cur != CTR_ST) nxt = cur + 2'd1;
        end else begin
            if (cur != CTR_SNT) nxt = cur - 2'd1;
        end
    end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit predictors.
// Stage-1 lookup is combinational on the stored arrays (no bypass of a
// same-cycle stage-4 write); stage-4 updates commit at the rising edge.
module branch_target_buffer
    import bp_pkg::*;
#(
    parameter int IDX_BITS = 4,
    parameter int PC_W     = 32,
    parameter int TAG_W    = PC_W - IDX_BITS - 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_s1,
    input  logic [PC_W-1:0] pc_s1,
    output logic            hit_s1,
    output logic            p_s1,
    output logic [PC_W-1:0] target_s1,
    input  logic [PC_W-1:0] pc_s4,
    input  logic [PC_W-1:0] target_s4,
    input  logic            deviated_s4,
    input  logic            write_rp,
    input  logic            write_rt,
    output logic [31:0]     lookup_count,
    output logic [31:0]     hit_count
);

    localparam int ENTRIES = 2 ** IDX_BITS;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [1:0]         ctr_arr_q [ENTRIES];
    logic [TAG_W-1:0]   tag_arr_q [ENTRIES];
    logic [PC_W-1:0]    tgt_arr_q [ENTRIES];
    logic [31:0]        lookup_count_q, lookup_count_d;
    logic [31:0]        hit_count_q, hit_count_d;

    logic [IDX_BITS-1:0] idx1, idx4;
    logic [TAG_W-1:0]    tag1, tag4;
    logic [1:0]          ctr_step;
    logic [1:0]          ctr_wdata;
    logic                ctr_we;
    logic [3:0]          unused_pc_lsbs;

    // Word-aligned PCs: the two low bits never take part in index or tag.
    assign idx1 = pc_s1[IDX_BITS+1:2];
    assign tag1 = pc_s1[PC_W-1:IDX_BITS+2];
    assign idx4 = pc_s4[IDX_BITS+1:2];
    assign tag4 = pc_s4[PC_W-1:IDX_BITS+2];
    assign unused_pc_lsbs = {pc_s1[1:0], pc_s4[1:0]};

    // Counter update path for an existing entry (write_rp without write_rt).
    sat_ctr2 u_sat_ctr2 (
        .cur (ctr_arr_q[idx4]),
        .inc (deviated_s4),
        .nxt (ctr_step)
    );

    // Stage-1 lookup; forced quiet during reset and on any miss.
    always_comb begin
        hit_s1    = 1'b0;
        p_s1      = 1'b0;
        target_s1 = '0;
        if (valid_s1 && !rst && valid_q[idx1] && (tag_arr_q[idx1] == tag1)) begin
            hit_s1    = 1'b1;
            p_s1      = ctr_arr_q[idx1][1];
            target_s1 = tgt_arr_q[idx1];
        end
    end

    // Stage-4 write decode: allocation seeds a weak counter, otherwise step it.
    always_comb begin
        ctr_we    = write_rt | write_rp;
        ctr_wdata = ctr_step;
        if (write_rt) ctr_wdata = deviated_s4 ? CTR_WT : CTR_WNT;
        valid_d = valid_q;
        if (write_rt) valid_d[idx4] = 1'b1;
    end

    // Statistics next-state; both counters wrap naturally at 2^32.
    always_comb begin
        lookup_count_d = lookup_count_q + {31'd0, valid_s1};
        hit_count_d    = hit_count_q + {31'd0, hit_s1};
    end

    // Valid bits, predictor counters and statistics; reset wins over writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q        <= '0;
            lookup_count_q <= '0;
            hit_count_q    <= '0;
            for (int i = 0; i < ENTRIES; i++) ctr_arr_q[i] <= CTR_WNT;
        end else begin
            valid_q        <= valid_d;
            lookup_count_q <= lookup_count_d;
            hit_count_q    <= hit_count_d;
            if (ctr_we) ctr_arr_q[idx4] <= ctr_wdata;
        end
    end

    // Tag and target storage: single write port, no reset needed since
    // the valid bit gates every read.
    always_ff @(posedge clk) begin
        if (!rst && write_rt) begin
            tag_arr_q[idx4] <= tag4;
            tgt_arr_q[idx4] <= target_s4;
        end
    end

    assign lookup_count = lookup_count_q;
    assign hit_count    = hit_count_q;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer: one task per scenario, each
// driving stimulus and checking outputs against hand-computed values.
module tb_branch_target_buffer;

    logic        clk;
    logic        rst;
    logic        valid_s1;
    logic [31:0] pc_s1;
    logic        hit_s1;
    logic        p_s1;
    logic [31:0] target_s1;
    logic [31:0] pc_s4;
    logic [31:0] target_s4;
    logic        deviated_s4;
    logic        write_rp;
    logic        write_rt;
    logic [31:0] lookup_count;
    logic [31:0] hit_count;

    int checks = 0;
    int errors = 0;
    int exp_lk = 0;
    int exp_ht = 0;
    logic cur_exp_hit = 1'b0;

    branch_target_buffer #(.IDX_BITS(4), .PC_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_s1     (valid_s1),
        .pc_s1        (pc_s1),
        .hit_s1       (hit_s1),
        .p_s1         (p_s1),
        .target_s1    (target_s1),
        .pc_s4        (pc_s4),
        .target_s4    (target_s4),
        .deviated_s4  (deviated_s4),
        .write_rp     (write_rp),
        .write_rt     (write_rt),
        .lookup_count (lookup_count),
        .hit_count    (hit_count)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic tick();
        if (valid_s1 && !rst) begin
            exp_lk++;
            if (cur_exp_hit) exp_ht++;
        end
        @(posedge clk);
        #1;
        valid_s1    = 1'b0;
        write_rp    = 1'b0;
        write_rt    = 1'b0;
        cur_exp_hit = 1'b0;
    endtask

    task automatic drive_lookup(input logic [31:0] pc, input logic exp_hit);
        valid_s1    = 1'b1;
        pc_s1       = pc;
        cur_exp_hit = exp_hit;
        #1;
    endtask

    task automatic drive_update(input logic [31:0] pc, input logic [31:0] tgt,
                                input logic dev, input logic rp, input logic rt);
        pc_s4       = pc;
        target_s4   = tgt;
        deviated_s4 = dev;
        write_rp    = rp;
        write_rt    = rt;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        valid_s1 = 1'b0; pc_s1 = '0; pc_s4 = '0; target_s4 = '0;
        deviated_s4 = 1'b0; write_rp = 1'b0; write_rt = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (lookup_count !== 32'd0 || hit_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_counts: got lk=%0d ht=%0d, want 0 0", lookup_count, hit_count);
        end
        checks++;
        if ({hit_s1, p_s1, target_s1} !== 34'd0) begin
            errors++;
            $display("FAIL idle_outputs: got hit=%b p=%b tgt=%h, want all 0", hit_s1, p_s1, target_s1);
        end
    endtask

    task automatic test_cold_miss();
        drive_lookup(32'h40, 1'b0);
        checks++;
        if ({hit_s1, p_s1, target_s1} !== 34'd0) begin
            errors++;
            $display("FAIL cold_miss: got hit=%b p=%b tgt=%h, want 0 0 0", hit_s1, p_s1, target_s1);
        end
        tick();
        checks++;
        if (lookup_count !== 32'd1 || hit_count !== 32'd0) begin
            errors++;
            $display("FAIL cold_counts: got lk=%0d ht=%0d, want 1 0", lookup_count, hit_count);
        end
    endtask

    task automatic test_allocate();
        drive_update(32'h40, 32'h100, 1'b1, 1'b1, 1'b1);
        tick();
        drive_lookup(32'h40, 1'b1);
        checks++;
        if ({hit_s1, p_s1, target_s1} !== {1'b1, 1'b1, 32'h100}) begin
            errors++;
            $display("FAIL allocate_hit: got hit=%b p=%b tgt=%h, want 1 1 00000100", hit_s1, p_s1, target_s1);
        end
        tick();
        checks++;
        if (lookup_count !== 32'd2 || hit_count !== 32'd1) begin
            errors++;
            $display("FAIL allocate_counts: got lk=%0d ht=%0d, want 2 1", lookup_count, hit_count);
        end
    endtask

    // Counter walk on 0x40 (starts at 10). Each row: deviated, rp, expected p after.
    task automatic test_counter();
        logic [2:0] steps [11];
        steps[0]  = 3'b111;  // +1 -> 11
        steps[1]  = 3'b111;  // +1 -> 11 (sat)
        steps[2]  = 3'b111;  // +1 -> 11 (sat)
        steps[3]  = 3'b011;  // -1 -> 10
        steps[4]  = 3'b010;  // -1 -> 01
        steps[5]  = 3'b010;  // -1 -> 00
        steps[6]  = 3'b010;  // -1 -> 00 (sat)
        steps[7]  = 3'b100;  // no write: hold 00
        steps[8]  = 3'b110;  // +1 -> 01
        steps[9]  = 3'b111;  // +1 -> 10
        steps[10] = 3'b000;  // no write: hold 10 (p=1 shown via bit0? see below)
        steps[10] = 3'b001;
        for (int i = 0; i < 11; i++) begin
            drive_update(32'h40, 32'hDEAD0000, steps[i][2], steps[i][1], 1'b0);
            tick();
            drive_lookup(32'h40, 1'b1);
            checks++;
            if ({hit_s1, p_s1, target_s1} !== {1'b1, steps[i][0], 32'h100}) begin
                errors++;
                $display("FAIL counter_step%0d: got hit=%b p=%b tgt=%h, want 1 %b 00000100",
                         i, hit_s1, p_s1, target_s1, steps[i][0]);
            end
            tick();
        end
    endtask

    task automatic test_alias();
        drive_lookup(32'h80, 1'b0);
        checks++;
        if (hit_s1 !== 1'b0) begin
            errors++;
            $display("FAIL alias_miss: got hit=%b, want 0", hit_s1);
        end
        tick();
        drive_update(32'h80, 32'h200, 1'b0, 1'b0, 1'b1);
        tick();
        drive_lookup(32'h40, 1'b0);
        checks++;
        if ({hit_s1, p_s1, target_s1} !== 34'd0) begin
            errors++;
            $display("FAIL alias_evict: got hit=%b p=%b tgt=%h, want 0 0 0", hit_s1, p_s1, target_s1);
        end
        tick();
        drive_lookup(32'h80, 1'b1);
        checks++;
        if ({hit_s1, p_s1, target_s1} !== {1'b1, 1'b0, 32'h200}) begin
            errors++;
            $display("FAIL alias_new: got hit=%b p=%b tgt=%h, want 1 0 00000200", hit_s1, p_s1, target_s1);
        end
        tick();
    endtask

    task automatic test_same_cycle();
        drive_update(32'h84, 32'h300, 1'b1, 1'b0, 1'b1);
        drive_lookup(32'h84, 1'b0);
        checks++;
        if (hit_s1 !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle_nobypass: got hit=%b, want 0", hit_s1);
        end
        tick();
        drive_lookup(32'h87, 1'b1);
        checks++;
        if ({hit_s1, p_s1, target_s1} !== {1'b1, 1'b1, 32'h300}) begin
            errors++;
            $display("FAIL same_cycle_next: got hit=%b p=%b tgt=%h, want 1 1 00000300", hit_s1, p_s1, target_s1);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        drive_update(32'h1008, 32'h400, 1'b0, 1'b1, 1'b1);
        tick();
        drive_update(32'h200C, 32'h500, 1'b1, 1'b1, 1'b1);
        drive_lookup(32'h1008, 1'b1);
        checks++;
        if ({hit_s1, p_s1, target_s1} !== {1'b1, 1'b0, 32'h400}) begin
            errors++;
            $display("FAIL b2b_first: got hit=%b p=%b tgt=%h, want 1 0 00000400", hit_s1, p_s1, target_s1);
        end
        tick();
        drive_lookup(32'h200C, 1'b1);
        checks++;
        if ({hit_s1, p_s1, target_s1} !== {1'b1, 1'b1, 32'h500}) begin
            errors++;
            $display("FAIL b2b_second: got hit=%b p=%b tgt=%h, want 1 1 00000500", hit_s1, p_s1, target_s1);
        end
        tick();
        checks++;
        if (lookup_count !== 32'(exp_lk) || hit_count !== 32'(exp_ht)) begin
            errors++;
            $display("FAIL stats_running: got lk=%0d ht=%0d, want %0d %0d", lookup_count, hit_count, exp_lk, exp_ht);
        end
    endtask

    task automatic test_reset_with_write();
        rst = 1'b1;
        drive_update(32'hC0, 32'h600, 1'b1, 1'b1, 1'b1);
        drive_lookup(32'h84, 1'b0);
        checks++;
        if ({hit_s1, p_s1, target_s1} !== 34'd0) begin
            errors++;
            $display("FAIL reset_cycle_hit: got hit=%b p=%b tgt=%h, want 0 0 0", hit_s1, p_s1, target_s1);
        end
        tick();
        rst = 1'b0;
        exp_lk = 0;
        exp_ht = 0;
        checks++;
        if (lookup_count !== 32'd0 || hit_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_counts: got lk=%0d ht=%0d, want 0 0", lookup_count, hit_count);
        end
        drive_lookup(32'hC0, 1'b0);
        checks++;
        if (hit_s1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_write_dropped: got hit=%b, want 0", hit_s1);
        end
        tick();
        drive_lookup(32'h84, 1'b0);
        checks++;
        if (hit_s1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_cleared_84: got hit=%b, want 0", hit_s1);
        end
        tick();
        drive_lookup(32'h200C, 1'b0);
        checks++;
        if (hit_s1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_cleared_200c: got hit=%b, want 0", hit_s1);
        end
        tick();
        checks++;
        if (lookup_count !== 32'd3 || hit_count !== 32'd0) begin
            errors++;
            $display("FAIL post_reset_counts: got lk=%0d ht=%0d, want 3 0", lookup_count, hit_count);
        end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_allocate();
        test_counter();
        test_alias();
        test_same_cycle();
        test_back_to_back();
        test_reset_with_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
